// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs a 32-bit immediate into the RV32I instruction fields selected by
//   ImmSrc and merges it with a base word that already carries the opcode,
//   register and funct fields. Flags immediates that the selected format
//   cannot represent. The encoded word leaves through a single registered
//   valid/ready stage, tagged with a sequential word address, and is meant
//   for instruction-memory preload in integration benches and loaders.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   clear      in   synchronous flush of the output stage and address counter
//   in_valid   in   request valid
//   in_ready   out  request accepted when in_valid && in_ready
//   ImmSrc     in   [2:0] 000 I, 001 S, 010 B, 011 J, 100 U, others illegal
//   imm        in   [31:0] immediate (byte offset for B/J)
//   base       in   [31:0] instruction with non-immediate fields populated
//   out_valid  out  encoded word valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   instr      out  [31:0] encoded instruction
//   out_addr   out  [ADDR_W-1:0] word address of the current instr
//   out_err    out  current word's immediate was not representable
//   err_count  out  [7:0] saturating count of erroneous words delivered

module imm_encoder #(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ImmSrc,
    input  logic [31:0]       imm,
    input  logic [31:0]       base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_err_count;

    logic [31:0]       w_instr;
    logic              w_legal;
    logic              w_fits_12;
    logic              w_fits_13;
    logic              w_fits_21;
    logic              w_accept;
    logic              w_out_hs;

    // Sign-extension checks: the bits above the format's sign bit must all
    // replicate that sign bit.
    assign w_fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        w_instr = base;
        w_legal = 1'b1;
        case (ImmSrc)
            SRC_I: begin
                w_instr[31:20] = imm[11:0];
                w_legal        = w_fits_12;
            end
            SRC_S: begin
                w_instr[31:25] = imm[11:5];
                w_instr[11:7]  = imm[4:0];
                w_legal        = w_fits_12;
            end
            SRC_B: begin
                w_instr[31]    = imm[12];
                w_instr[30:25] = imm[10:5];
                w_instr[11:8]  = imm[4:1];
                w_instr[7]     = imm[11];
                w_legal        = ~imm[0] & w_fits_13;
            end
            SRC_J: begin
                w_instr[31]    = imm[20];
                w_instr[30:21] = imm[10:1];
                w_instr[20]    = imm[11];
                w_instr[19:12] = imm[19:12];
                w_legal        = ~imm[0] & w_fits_21;
            end
            SRC_U: begin
                w_instr[31:12] = imm[31:12];
                w_legal        = ~(|imm[11:0]);
            end
            default: begin
                w_instr = base;
                w_legal = 1'b0;
            end
        endcase
    end

    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_out_hs = r_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_err       <= 1'b0;
            r_addr      <= START_ADDR;
            r_err_count <= '0;
        end else if (clear) begin
            // err_count deliberately survives a clear
            r_valid <= 1'b0;
            r_instr <= '0;
            r_err   <= 1'b0;
            r_addr  <= START_ADDR;
        end else begin
            if (w_out_hs) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            // A new word may replace a departing one in the same cycle.
            if (w_accept) begin
                r_valid <= 1'b1;
                r_instr <= w_instr;
                r_err   <= ~w_legal;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign instr     = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;
    assign err_count = r_err_count;

endmodule
